// File: rtl/draw_bg_fader_pkg.sv
// Shared types, colour constants and pixel helpers for the background fader.
package draw_bg_fader_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_MULTI  = 2'd2,
        MODE_PAUSE  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } state_e;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } timing_t;

    localparam logic [11:0] COL_BG     = 12'h02F;
    localparam logic [11:0] COL_LINE   = 12'hFFF;
    localparam logic [11:0] COL_FIELD  = 12'h555;
    localparam logic [11:0] COL_BLACK  = 12'h000;
    localparam logic [11:0] COL_TOP    = 12'hFF0;
    localparam logic [11:0] COL_BOTTOM = 12'hF00;
    localparam logic [11:0] COL_LEFT   = 12'h0F0;
    localparam logic [11:0] COL_RIGHT  = 12'h00F;
    localparam logic [11:0] COL_NET_MP = 12'hFF0;

    localparam logic [3:0] LEVEL_MAX = 4'd15;

    // Per-nibble c * (level + 1) >> 4 in 8-bit unsigned arithmetic.
    function automatic logic [11:0] scale_rgb(input logic [11:0] rgb, input logic [3:0] level);
        logic [7:0]  gain;
        logic [7:0]  prod;
        logic [11:0] res;
        gain = 8'(level) + 8'd1;
        res  = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            prod             = 8'(rgb[i*4 +: 4]) * gain;
            res[i*4 +: 4]    = 4'(prod >> 4);
        end
        return res;
    endfunction

    function automatic logic [11:0] dim_rgb(input logic [11:0] rgb);
        return (rgb >> 1) & 12'h777;
    endfunction

endpackage

// File: rtl/draw_bg_fader_if.sv
// VGA timing bundle (counters, syncs, blanking) passed between pipeline stages.
interface draw_bg_fader_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/draw_bg_fader_fade_ctrl.sv
// Frame-tick detect and layout-switch control; DRAW_BG_FADE_EN selects the
// fade-out/fade-in sequencer, otherwise the layout switches on the next tick.
module draw_bg_fader_fade_ctrl
    import draw_bg_fader_pkg::*;
#(
    parameter int unsigned FADE_STEP = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       vblnk_i,
    input  mode_e      mode_req_i,
`ifdef DRAW_BG_FADE_EN
    output logic [3:0] level_o,
`endif
    output mode_e      mode_cur_o,
    output logic       busy_o
);

    logic vblnk_prev_q;
    logic tick;

    assign tick = vblnk_i & ~vblnk_prev_q;

    // Reset to 1 so a vblank already high at release is not seen as a tick.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) vblnk_prev_q <= 1'b1;
        else         vblnk_prev_q <= vblnk_i;
    end

`ifdef DRAW_BG_FADE_EN
    localparam logic [4:0] STEP = 5'(FADE_STEP);

    state_e     state_q;
    logic [3:0] level_q;
    mode_e      mode_cur_q;
    logic       busy_q;
    logic [4:0] level_sum;
    logic [3:0] level_dn;
    logic [3:0] level_up;

    always_comb begin
        level_dn  = ({1'b0, level_q} >= STEP) ? 4'({1'b0, level_q} - STEP) : 4'd0;
        level_sum = {1'b0, level_q} + STEP;
        level_up  = (level_sum > 5'(LEVEL_MAX)) ? LEVEL_MAX : level_sum[3:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= SHOW;
            level_q    <= LEVEL_MAX;
            mode_cur_q <= MODE_IDLE;
            busy_q     <= 1'b0;
        end else if (tick) begin
            unique case (state_q)
                SHOW: begin
                    if (mode_req_i != mode_cur_q) begin
                        state_q <= FADE_OUT;
                        busy_q  <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    if (level_q == 4'd0) begin
                        mode_cur_q <= mode_req_i;
                        state_q    <= FADE_IN;
                    end else begin
                        level_q <= level_dn;
                    end
                end
                FADE_IN: begin
                    if (level_q == LEVEL_MAX) begin
                        state_q <= SHOW;
                        busy_q  <= 1'b0;
                    end else begin
                        level_q <= level_up;
                    end
                end
                default: state_q <= SHOW;
            endcase
        end
    end

    assign level_o    = level_q;
    assign mode_cur_o = mode_cur_q;
    assign busy_o     = busy_q;
`else
    mode_e mode_cur_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)                             mode_cur_q <= MODE_IDLE;
        else if (tick && mode_req_i != mode_cur_q) mode_cur_q <= mode_req_i;
    end

    assign mode_cur_o = mode_cur_q;
    assign busy_o     = (mode_req_i != mode_cur_q);
`endif

endmodule

// File: rtl/draw_bg_fader.sv
// Layout background renderer with a 2-stage pixel pipeline and per-frame
// cross-fade on mode change (fade enabled by defining DRAW_BG_FADE_EN).
module draw_bg_fader
    import draw_bg_fader_pkg::*;
#(
    parameter int HOR_PIXELS = 1024,
    parameter int VER_PIXELS = 768,
    parameter int H_START    = 80,
    parameter int H_SIZE     = 863,
    parameter int V_START    = 80,
    parameter int V_SIZE     = 607,
    parameter int BAR_TOP    = 51,
    parameter int BAR_BOT    = 717,
    parameter int NET_X0     = 506,
    parameter int NET_X1     = 516,
    parameter int FADE_STEP  = 1
) (
    input  logic                   clk65MHz,
    input  logic                   rst_n,
    input  logic [1:0]             mode_req,
    draw_bg_fader_if.slave         tim_in,
    draw_bg_fader_if.master        tim_out,
    output logic [11:0]            out_rgb,
    output logic [1:0]             mode_cur,
    output logic                   busy
);

    localparam logic [10:0] H_LAST    = 11'(HOR_PIXELS - 1);
    localparam logic [10:0] V_LAST    = 11'(VER_PIXELS - 1);
    localparam logic [10:0] FIELD_X0  = 11'(H_START);
    localparam logic [10:0] FIELD_X1  = 11'(H_START + H_SIZE);
    localparam logic [10:0] FIELD_Y0  = 11'(V_START);
    localparam logic [10:0] FIELD_Y1  = 11'(V_START + V_SIZE);
    localparam logic [10:0] BAR_TOP_C = 11'(BAR_TOP);
    localparam logic [10:0] BAR_BOT_C = 11'(BAR_BOT);
    localparam logic [10:0] NET_X0_C  = 11'(NET_X0);
    localparam logic [10:0] NET_X1_C  = 11'(NET_X1);

    mode_e       mode_cur_e;
    timing_t     tim_in_s;
    timing_t     tim_s1_q;
    timing_t     tim_s2_q;
    logic [11:0] rgb_s1_d;
    logic [11:0] rgb_s1_q;
    logic [11:0] rgb_s2_d;
    logic [11:0] rgb_s2_q;
    logic [10:0] hc;
    logic [10:0] vc;
`ifdef DRAW_BG_FADE_EN
    logic [3:0]  level;
`endif

    draw_bg_fader_fade_ctrl #(
        .FADE_STEP (FADE_STEP)
    ) u_fade_ctrl (
        .clk_i      (clk65MHz),
        .rst_ni     (rst_n),
        .vblnk_i    (tim_in.vblnk),
        .mode_req_i (mode_e'(mode_req)),
`ifdef DRAW_BG_FADE_EN
        .level_o    (level),
`endif
        .mode_cur_o (mode_cur_e),
        .busy_o     (busy)
    );

    assign tim_in_s = {tim_in.hcount, tim_in.vcount, tim_in.hsync,
                       tim_in.vsync, tim_in.hblnk, tim_in.vblnk};
    assign hc = tim_in.hcount;
    assign vc = tim_in.vcount;

    always_comb begin
        rgb_s1_d = COL_BLACK;
        if (tim_in.hblnk || tim_in.vblnk) begin
            rgb_s1_d = COL_BLACK;
        end else if (mode_cur_e == MODE_IDLE) begin
            if      (vc == '0)     rgb_s1_d = COL_TOP;
            else if (vc == V_LAST) rgb_s1_d = COL_BOTTOM;
            else if (hc == '0)     rgb_s1_d = COL_LEFT;
            else if (hc == H_LAST) rgb_s1_d = COL_RIGHT;
            else if (hc >= FIELD_X0 && hc < FIELD_X1 && vc >= FIELD_Y0 && vc < FIELD_Y1)
                rgb_s1_d = COL_FIELD;
            else
                rgb_s1_d = COL_BG;
        end else begin
            if (vc < BAR_TOP_C || vc > BAR_BOT_C)
                rgb_s1_d = COL_LINE;
            else if (hc >= NET_X0_C && hc <= NET_X1_C)
                rgb_s1_d = (mode_cur_e == MODE_MULTI) ? COL_NET_MP : COL_LINE;
            else
                rgb_s1_d = COL_BG;
        end
    end

    // Blanked pixels are already black, so scaling and dimming keep them black.
    always_comb begin
        rgb_s2_d = rgb_s1_q;
`ifdef DRAW_BG_FADE_EN
        rgb_s2_d = scale_rgb(rgb_s1_q, level);
`endif
        if (mode_cur_e == MODE_PAUSE) rgb_s2_d = dim_rgb(rgb_s2_d);
    end

    always_ff @(posedge clk65MHz) begin
        if (!rst_n) begin
            tim_s1_q <= '0;
            rgb_s1_q <= '0;
            tim_s2_q <= '0;
            rgb_s2_q <= '0;
        end else begin
            tim_s1_q <= tim_in_s;
            rgb_s1_q <= rgb_s1_d;
            tim_s2_q <= tim_s1_q;
            rgb_s2_q <= rgb_s2_d;
        end
    end

    assign tim_out.hcount = tim_s2_q.hcount;
    assign tim_out.vcount = tim_s2_q.vcount;
    assign tim_out.hsync  = tim_s2_q.hsync;
    assign tim_out.vsync  = tim_s2_q.vsync;
    assign tim_out.hblnk  = tim_s2_q.hblnk;
    assign tim_out.vblnk  = tim_s2_q.vblnk;
    assign out_rgb        = rgb_s2_q;
    assign mode_cur       = mode_cur_e;

endmodule

// File: tb/tb_draw_bg_fader.sv
// Directed self-checking bench for draw_bg_fader; follows DRAW_BG_FADE_EN
// so the same stimulus covers both the fading and the instant-switch builds.
module tb_draw_bg_fader;

    logic        clk65MHz = 1'b0;
    logic        rst_n;
    logic [1:0]  mode_req;
    logic [11:0] out_rgb;
    logic [1:0]  mode_cur;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    draw_bg_fader_if tin();
    draw_bg_fader_if tout();

    draw_bg_fader #(
        .HOR_PIXELS (1024),
        .VER_PIXELS (768),
        .FADE_STEP  (1)
    ) dut (
        .clk65MHz (clk65MHz),
        .rst_n    (rst_n),
        .mode_req (mode_req),
        .tim_in   (tin),
        .tim_out  (tout),
        .out_rgb  (out_rgb),
        .mode_cur (mode_cur),
        .busy     (busy)
    );

    always #5 clk65MHz = ~clk65MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel, hold it until it has crossed both stages, check colour.
    task automatic pix(input string tag, input logic [10:0] h, input logic [10:0] v,
                       input logic hb, input logic [11:0] exp);
        @(posedge clk65MHz); #1;
        tin.hcount = h;
        tin.vcount = v;
        tin.hblnk  = hb;
        tin.hsync  = hb;
        tin.vsync  = 1'b0;
        tin.vblnk  = 1'b0;
        @(posedge clk65MHz);
        @(posedge clk65MHz); #1;
        chk(tag, 32'(out_rgb), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk65MHz); #1 tin.vblnk = 1'b1;
        @(posedge clk65MHz); #1 tin.vblnk = 1'b0;
        @(posedge clk65MHz); #1;
    endtask

    task automatic check_single();
        pix("single_net_mid",  11'd510, 11'd300, 1'b0, 12'hFFF);
        pix("single_topbar",   11'd300, 11'd20,  1'b0, 12'hFFF);
        pix("single_bg",       11'd300, 11'd300, 1'b0, 12'h02F);
        pix("single_row50",    11'd300, 11'd50,  1'b0, 12'hFFF);
        pix("single_row51",    11'd300, 11'd51,  1'b0, 12'h02F);
        pix("single_row717",   11'd300, 11'd717, 1'b0, 12'h02F);
        pix("single_row718",   11'd300, 11'd718, 1'b0, 12'hFFF);
        pix("single_col505",   11'd505, 11'd300, 1'b0, 12'h02F);
        pix("single_col506",   11'd506, 11'd300, 1'b0, 12'hFFF);
        pix("single_col516",   11'd516, 11'd300, 1'b0, 12'hFFF);
        pix("single_col517",   11'd517, 11'd300, 1'b0, 12'h02F);
    endtask

    task automatic check_multi();
        pix("multi_net",    11'd510, 11'd300, 1'b0, 12'hFF0);
        pix("multi_net506", 11'd506, 11'd300, 1'b0, 12'hFF0);
        pix("multi_topbar", 11'd300, 11'd20,  1'b0, 12'hFFF);
        pix("multi_bg",     11'd300, 11'd300, 1'b0, 12'h02F);
    endtask

    task automatic check_pause();
        pix("pause_net",    11'd510, 11'd300, 1'b0, 12'h777);
        pix("pause_bg",     11'd300, 11'd300, 1'b0, 12'h017);
        pix("pause_topbar", 11'd300, 11'd20,  1'b0, 12'h777);
        pix("pause_blank",  11'd300, 11'd300, 1'b1, 12'h000);
    endtask

`ifdef DRAW_BG_FADE_EN
    task automatic full_fade(input logic [1:0] m, input logic [1:0] from);
        mode_req = m; #1;
        chk("ff_busy_wait", 32'(busy), 32'd0);
        tick();
        chk("ff_busy_rise", 32'(busy), 32'd1);
        repeat (15) tick();
        chk("ff_mode_hold", 32'(mode_cur), 32'(from));
        tick();
        chk("ff_mode_switch", 32'(mode_cur), 32'(m));
        repeat (15) tick();
        chk("ff_busy_fadein", 32'(busy), 32'd1);
        tick();
        chk("ff_busy_fall", 32'(busy), 32'd0);
    endtask
`else
    task automatic switch_now(input logic [1:0] m, input logic [1:0] from);
        mode_req = m; #1;
        chk("sw_busy", 32'(busy), 32'd1);
        chk("sw_hold", 32'(mode_cur), 32'(from));
        tick();
        chk("sw_mode", 32'(mode_cur), 32'(m));
        chk("sw_done", 32'(busy), 32'd0);
    endtask
`endif

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        mode_req   = 2'd0;
        tin.hcount = 11'd5;
        tin.vcount = 11'd7;
        tin.hsync  = 1'b1;
        tin.vsync  = 1'b1;
        tin.hblnk  = 1'b0;
        tin.vblnk  = 1'b1;
        repeat (5) @(posedge clk65MHz);
        #1;
        chk("rst_hcount",   32'(tout.hcount), 32'd0);
        chk("rst_vcount",   32'(tout.vcount), 32'd0);
        chk("rst_hsync",    32'(tout.hsync),  32'd0);
        chk("rst_vsync",    32'(tout.vsync),  32'd0);
        chk("rst_vblnk",    32'(tout.vblnk),  32'd0);
        chk("rst_rgb",      32'(out_rgb),     32'd0);
        chk("rst_mode_cur", 32'(mode_cur),    32'd0);
        chk("rst_busy",     32'(busy),        32'd0);

        // vblank already high at release must not count as a frame tick
        mode_req = 2'd1;
        rst_n    = 1'b1;
        repeat (2) @(posedge clk65MHz);
        #1;
        chk("no_spurious_tick", 32'(mode_cur), 32'd0);
`ifdef DRAW_BG_FADE_EN
        chk("no_spurious_busy", 32'(busy), 32'd0);
`endif
        mode_req  = 2'd0;
        tin.vblnk = 1'b0;
        tin.hsync = 1'b0;
        tin.vsync = 1'b0;

        // idle layout and pipeline latency
        pix("idle_field", 11'd100, 11'd100, 1'b0, 12'h555);
        @(posedge clk65MHz); #1;
        tin.hcount = 11'd10;
        tin.vcount = 11'd10;
        @(posedge clk65MHz); #1;
        chk("lat_1cyc_rgb",    32'(out_rgb),     32'h555);
        chk("lat_1cyc_hcount", 32'(tout.hcount), 32'd100);
        @(posedge clk65MHz); #1;
        chk("lat_2cyc_rgb",    32'(out_rgb),     32'h02F);
        chk("lat_2cyc_hcount", 32'(tout.hcount), 32'd10);
        chk("lat_2cyc_vcount", 32'(tout.vcount), 32'd10);

        pix("idle_top",       11'd500,  11'd0,   1'b0, 12'hFF0);
        pix("idle_corner",    11'd0,    11'd0,   1'b0, 12'hFF0);
        pix("idle_bottom",    11'd500,  11'd767, 1'b0, 12'hF00);
        pix("idle_left",      11'd0,    11'd300, 1'b0, 12'h0F0);
        pix("idle_right",     11'd1023, 11'd300, 1'b0, 12'h00F);
        pix("idle_fx0",       11'd80,   11'd80,  1'b0, 12'h555);
        pix("idle_fx0_out",   11'd79,   11'd80,  1'b0, 12'h02F);
        pix("idle_fx1",       11'd942,  11'd686, 1'b0, 12'h555);
        pix("idle_fx1_out",   11'd943,  11'd100, 1'b0, 12'h02F);
        pix("idle_fy1_out",   11'd100,  11'd687, 1'b0, 12'h02F);
        pix("idle_hblank",    11'd100,  11'd100, 1'b1, 12'h000);
        chk("hblnk_delayed", 32'(tout.hblnk), 32'd1);
        chk("hsync_delayed", 32'(tout.hsync), 32'd1);

        @(posedge clk65MHz); #1;
        tin.hblnk  = 1'b0;
        tin.hsync  = 1'b0;
        tin.vsync  = 1'b1;
        tin.vblnk  = 1'b1;
        repeat (2) @(posedge clk65MHz);
        #1;
        chk("idle_vblank", 32'(out_rgb),     32'h000);
        chk("vsync_delayed", 32'(tout.vsync), 32'd1);
        tin.vsync = 1'b0;
        tin.vblnk = 1'b0;

`ifdef DRAW_BG_FADE_EN
        mode_req = 2'd1; #1;
        chk("fade_busy_wait", 32'(busy), 32'd0);
        tick();
        chk("fade_busy_rise", 32'(busy), 32'd1);
        chk("fade_mode_hold", 32'(mode_cur), 32'd0);
        pix("fade_l15", 11'd100, 11'd100, 1'b0, 12'h555);
        repeat (8) tick();
        pix("fade_l7", 11'd100, 11'd100, 1'b0, 12'h222);
        repeat (7) tick();
        pix("fade_l0", 11'd100, 11'd100, 1'b0, 12'h000);
        chk("fade_l0_mode", 32'(mode_cur), 32'd0);
        tick();
        chk("fade_switch_mode", 32'(mode_cur), 32'd1);
        pix("fadein_l0", 11'd300, 11'd20, 1'b0, 12'h000);
        repeat (5) tick();
        mode_req = 2'd2;
        repeat (10) tick();
        chk("rereq_busy", 32'(busy), 32'd1);
        chk("rereq_mode", 32'(mode_cur), 32'd1);
        tick();
        chk("rereq_show", 32'(busy), 32'd0);
        chk("rereq_mode_kept", 32'(mode_cur), 32'd1);
        check_single();
        full_fade(2'd2, 2'd1);
        check_multi();
        full_fade(2'd3, 2'd2);
        check_pause();
        mode_req = 2'd0;
        tick();
        tick();
        tick();
        chk("midfade_busy", 32'(busy), 32'd1);
`else
        switch_now(2'd1, 2'd0);
        check_single();
        mode_req = 2'd3;
        repeat (2) @(posedge clk65MHz);
        #1;
        chk("rereq_busy", 32'(busy), 32'd1);
        chk("rereq_hold", 32'(mode_cur), 32'd1);
        mode_req = 2'd2;
        tick();
        chk("rereq_mode", 32'(mode_cur), 32'd2);
        chk("rereq_done", 32'(busy), 32'd0);
        check_multi();
        switch_now(2'd3, 2'd2);
        check_pause();
        mode_req = 2'd0; #1;
        chk("midswitch_busy", 32'(busy), 32'd1);
`endif

        @(posedge clk65MHz); #1 rst_n = 1'b0;
        @(posedge clk65MHz); #1 rst_n = 1'b1;
        chk("midrst_mode", 32'(mode_cur), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        pix("midrst_full", 11'd100, 11'd100, 1'b0, 12'h555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
